// File: rtl/vga_scanout_engine_pkg.sv
// Shared timing defaults, pixel colour type and width helpers for the VGA scan-out engine
// and the raster timing generator.
package vga_scanout_engine_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_BPP      = 8;
    localparam int DEF_SCALE    = 1;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb_t;

    function automatic int vga_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Register width able to hold 0..n-1, never narrower than one bit.
    function automatic int vga_width(input int n);
        return (n > 1) ? vga_clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_scanout_engine_if.sv
// Video-memory read port plus the CPU framebuffer-base write port of the scan-out engine.
interface vga_scanout_engine_if;

    logic [31:0] vid_adr;
    logic [31:0] vid_data;
    logic [31:0] fb_base;
    logic        fb_base_we;

    modport master (
        output vid_adr,
        input  vid_data,
        input  fb_base,
        input  fb_base_we
    );

    modport slave (
        input  vid_adr,
        output vid_data,
        output fb_base,
        output fb_base_we
    );

endinterface

// File: rtl/vga_timing_gen.sv
// Pixel clock-enable divider and raster counters with raw syncs, active flag and frame-start pulse.
module vga_timing_gen
    import vga_scanout_engine_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    localparam int H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = vga_width(H_TOT),
    localparam int VW      = vga_width(V_TOT)
) (
    input  logic          CLK,
    input  logic          reset,
    output logic          pix_ce,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          hsync_raw,
    output logic          vsync_raw,
    output logic          active,
    output logic          frame_start
);

    localparam int DW       = vga_width(CLK_DIV);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [DW-1:0] div;
    logic [31:0]   h32;
    logic [31:0]   v32;

    assign pix_ce = (div == DW'(CLK_DIV - 1));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (pix_ce) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_ce) begin
            if (hcnt == HW'(H_TOT - 1)) begin
                hcnt <= '0;
                vcnt <= (vcnt == VW'(V_TOT - 1)) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Sync windows are compared at 32 bits so a window ending exactly at 2**HW cannot wrap.
    assign h32 = 32'(hcnt);
    assign v32 = 32'(vcnt);

    assign hsync_raw   = !((h32 >= 32'(HS_START)) && (h32 < 32'(HS_END)));
    assign vsync_raw   = !((v32 >= 32'(VS_START)) && (v32 < 32'(VS_END)));
    assign active      = (h32 < 32'(H_ACTIVE)) && (v32 < 32'(V_ACTIVE));
    assign frame_start = pix_ce && (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/vga_scanout_engine.sv
// Framebuffer scan-out: double-buffered base, pixel address generation, word fetch,
// BPP unpacking with replication to RRRGGGBB, and sync alignment with the pixel pipeline.
module vga_scanout_engine
    import vga_scanout_engine_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int BPP      = DEF_BPP,
    parameter int SCALE    = DEF_SCALE
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        en,
    vga_scanout_engine_if.master        vid,
    output logic                        hsync,
    output logic                        vsync,
    output logic [2:0]                  VGA_R,
    output logic [2:0]                  VGA_G,
    output logic [1:0]                  VGA_B,
    output logic                        frame_start
);

    localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = vga_width(H_TOT);
    localparam int VW       = vga_width(V_TOT);
    localparam int SW       = H_ACTIVE / SCALE;
    localparam int PPW      = 32 / BPP;
    localparam int SEL_W    = vga_width(PPW);
    localparam int SCALE_SH = vga_clog2(SCALE);
    localparam int PPW_SH   = vga_clog2(PPW);

    logic          pix_ce;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          hsync_raw;
    logic          vsync_raw;
    logic          active;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV)
    ) u_timing (
        .CLK         (CLK),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw),
        .active      (active),
        .frame_start (frame_start)
    );

    // MSB-first replication of a BPP-bit pixel to 8 bits, read as RRRGGGBB.
    function automatic rgb_t map_pixel(input logic [BPP-1:0] p);
        return rgb_t'({(8 / BPP){p}});
    endfunction

    logic [31:0]      pending_base;
    logic [31:0]      active_base;
    logic [31:0]      base_eff;
    logic             en_act;
    logic             en_eff;
    logic             fetch;
    logic [31:0]      sx;
    logic [31:0]      sy;
    logic [31:0]      pix_idx;
    logic [31:0]      adr_next;
    logic [SEL_W-1:0] sel_next;
    logic [SEL_W-1:0] sel_p0;
    logic             vis_p0;
    logic             hs_p0;
    logic             vs_p0;
    logic [BPP-1:0]   pix_raw;
    rgb_t             rgb_next;

    // On the frame-start tick the incoming base/enable are used directly, so the first
    // pixel of the new frame already fetches from the new buffer.
    assign base_eff = frame_start ? (vid.fb_base_we ? vid.fb_base : pending_base) : active_base;
    assign en_eff   = frame_start ? en : en_act;
    assign fetch    = active && en_eff;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pending_base <= '0;
            active_base  <= '0;
            en_act       <= 1'b0;
        end else begin
            if (vid.fb_base_we) begin
                pending_base <= vid.fb_base;
            end
            if (frame_start) begin
                active_base <= base_eff;
                en_act      <= en;
            end
        end
    end

    assign sx       = 32'(hcnt) >> SCALE_SH;
    assign sy       = 32'(vcnt) >> SCALE_SH;
    assign pix_idx  = sy * 32'(SW) + sx;
    assign adr_next = base_eff + ((pix_idx >> PPW_SH) << 2);
    assign sel_next = SEL_W'(pix_idx & 32'(PPW - 1));

    // S0: word address to memory, pixel-in-word select, first sync/visibility delay
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            vid.vid_adr <= '0;
            vis_p0      <= 1'b0;
            hs_p0       <= 1'b1;
            vs_p0       <= 1'b1;
        end else if (pix_ce) begin
            vis_p0 <= fetch;
            hs_p0  <= hsync_raw;
            vs_p0  <= vsync_raw;
            if (fetch) begin
                vid.vid_adr <= adr_next;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (pix_ce && fetch) begin
            sel_p0 <= sel_next;
        end
    end

    // S1: read word arrives one CLK after the address; extract the selected pixel (pixel 0 in LSBs)
    assign pix_raw  = BPP'(vid.vid_data >> (32'(sel_p0) * 32'(BPP)));
    assign rgb_next = map_pixel(pix_raw);

    // S2: registered colour and syncs, blanked outside the visible, enabled area
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
        end else if (pix_ce) begin
            hsync <= hs_p0;
            vsync <= vs_p0;
            VGA_R <= vis_p0 ? rgb_next.r : 3'd0;
            VGA_G <= vis_p0 ? rgb_next.g : 3'd0;
            VGA_B <= vis_p0 ? rgb_next.b : 2'd0;
        end
    end

endmodule
